// File: rtl/spi_pwm_ctrl.sv
// SPI (mode 0) register interface driving CHANNELS outputs, each either static or gated by a
// shared prescaled 255-step PWM. Read-back shifts out on cipo during the data phase of a read frame.
module spi_pwm_ctrl #(
  parameter int         CHANNELS      = 16,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] DEFAULT_PRESC = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                copi,
  input  logic                ncs,
  output logic                cipo,
  output logic                cipo_oe,
  output logic [CHANNELS-1:0] outs
);
  localparam int B          = CHANNELS / 8;
  localparam int ADDR_DUTY  = 2 * B;
  localparam int ADDR_PRESC = 2 * B + 1;
  localparam int SETTLE_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_reg, copi_sync_reg, ncs_sync_reg;
  logic sclk_d_reg, ncs_d_reg;
  logic [SETTLE_W-1:0] settle_cnt_reg;
  logic armed_reg, in_frame_reg, tx_active_reg, cipo_reg;
  logic [4:0]  bit_cnt_reg;
  logic [15:0] rx_reg;
  logic [7:0]  tx_reg;
  logic [CHANNELS-1:0] en_out_reg, en_pwm_reg, outs_reg, outs_next;
  logic [7:0] duty_reg, presc_reg, presc_cnt_reg, period_cnt_reg, rd_data;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, sclk_fall, ncs_rise, frame_start, wr_commit, tick, pwm;
  logic [15:0] rx_next;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      copi_sync_reg <= '0;
      ncs_sync_reg  <= '1;
      sclk_d_reg    <= 1'b0;
      ncs_d_reg     <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], copi};
      ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], ncs};
      sclk_d_reg    <= sclk_s;
      ncs_d_reg     <= ncs_s;
    end
  end

  assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
  assign copi_s      = copi_sync_reg[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_d_reg;
  assign sclk_fall   = ~sclk_s & sclk_d_reg;
  assign ncs_rise    = ncs_s & ~ncs_d_reg;
  assign frame_start = armed_reg & ncs_d_reg & ~ncs_s;
  assign rx_next     = {rx_reg[14:0], copi_s};

  // The synchroniser resets to idle, so a low ncs held through reset would look like a
  // fresh fall; only arm frame detection once real samples have shown ncs high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_reg <= '0;
      armed_reg      <= 1'b0;
    end else begin
      if (settle_cnt_reg != SETTLE_MAX) settle_cnt_reg <= settle_cnt_reg + 1'b1;
      if (settle_cnt_reg == SETTLE_MAX && ncs_s && ncs_d_reg) armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_reg  <= 1'b0;
      tx_active_reg <= 1'b0;
      cipo_reg      <= 1'b0;
      bit_cnt_reg   <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
    end else if (frame_start) begin
      in_frame_reg  <= 1'b1;
      tx_active_reg <= 1'b0;
      cipo_reg      <= 1'b0;
      bit_cnt_reg   <= '0;
    end else if (ncs_rise) begin
      in_frame_reg  <= 1'b0;
      tx_active_reg <= 1'b0;
      cipo_reg      <= 1'b0;
    end else if (in_frame_reg && sclk_rise) begin
      rx_reg <= rx_next;
      if (bit_cnt_reg != 5'd31) bit_cnt_reg <= bit_cnt_reg + 5'd1;
      // Header complete on the 8th rise: rx_next[7] is the R/W flag, [6:0] the address.
      if (bit_cnt_reg == 5'd7 && !rx_next[7]) begin
        tx_reg        <= rd_data;
        tx_active_reg <= 1'b1;
      end
    end else if (tx_active_reg && sclk_fall) begin
      cipo_reg <= tx_reg[7];
      tx_reg   <= {tx_reg[6:0], 1'b0};
    end
  end

  assign wr_commit = ncs_rise & in_frame_reg & (bit_cnt_reg == 5'd16) & rx_reg[15];
  assign wr_addr   = rx_reg[14:8];
  assign wr_data   = rx_reg[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_reg <= '0;
      en_pwm_reg <= '0;
      duty_reg   <= '0;
      presc_reg  <= DEFAULT_PRESC;
    end else if (wr_commit) begin
      for (int k = 0; k < B; k++) begin
        if (wr_addr == 7'(k))     en_out_reg[8*k +: 8] <= wr_data;
        if (wr_addr == 7'(B + k)) en_pwm_reg[8*k +: 8] <= wr_data;
      end
      if (wr_addr == 7'(ADDR_DUTY))  duty_reg  <= wr_data;
      if (wr_addr == 7'(ADDR_PRESC)) presc_reg <= wr_data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < B; k++) begin
      if (rx_next[6:0] == 7'(k))     rd_data = en_out_reg[8*k +: 8];
      if (rx_next[6:0] == 7'(B + k)) rd_data = en_pwm_reg[8*k +: 8];
    end
    if (rx_next[6:0] == 7'(ADDR_DUTY))  rd_data = duty_reg;
    if (rx_next[6:0] == 7'(ADDR_PRESC)) rd_data = presc_reg;
  end

  assign tick = (presc_cnt_reg == presc_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_reg  <= '0;
      period_cnt_reg <= '0;
    end else begin
      if ((wr_commit && wr_addr == 7'(ADDR_PRESC)) || tick) presc_cnt_reg <= '0;
      else                                                  presc_cnt_reg <= presc_cnt_reg + 8'd1;
      if (tick) period_cnt_reg <= (period_cnt_reg == 8'd254) ? 8'd0 : period_cnt_reg + 8'd1;
    end
  end

  assign pwm = (duty_reg == 8'hFF) | (period_cnt_reg < duty_reg);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_out
    assign outs_next[gi] = en_out_reg[gi] & (~en_pwm_reg[gi] | pwm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outs_reg <= '0;
    else        outs_reg <= outs_next;
  end

  assign outs    = outs_reg;
  assign cipo    = cipo_reg;
  assign cipo_oe = tx_active_reg;
endmodule

// File: doc/spi_pwm_ctrl.md
# spi_pwm_ctrl

SPI-controlled, parametrised multi-channel output/PWM controller; the next generation of the 16-output SPI+PWM core that sits behind the Tiny Tapeout wrapper. Channel count is parametrised and the register map adds a programmable PWM prescaler and SPI read-back on a dedicated CIPO pin. The wrapper maps `sclk`, `copi` and `ncs` to `ui_in`, and `outs` and `cipo` to `uo_out`/`uio_out`.

## Interface
- `CHANNELS`, default 16: number of outputs; a multiple of 8, from 8 to 32. `B = CHANNELS/8` register bytes per bank.
- `SYNC_STAGES`, default 2: flip-flop stages on `sclk`, `copi` and `ncs`; minimum 2.
- `DEFAULT_PRESC`, default 8'h00: reset value of the prescaler register.
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: asynchronous active-low reset.
- `sclk` in 1: SPI clock, mode 0, asynchronous to `clk`.
- `copi` in 1: SPI data in, MSB first.
- `ncs` in 1: active-low chip select.
- `cipo` out 1: SPI read data.
- `cipo_oe` out 1: high while `cipo` is driven.
- `outs` out CHANNELS: channel outputs.

## Operation
- Synchronisers: `sclk`, `copi` and `ncs` each pass through `SYNC_STAGES` flip-flops. Edges are detected on the synchronised `sclk`/`ncs` against one extra registered copy.
- Frame: 16 bits, MSB first.
  - bit15: 1 = write, 0 = read.
  - bits14:8: 7-bit address.
  - bits7:0: data.
- `copi` is sampled on each synchronised `sclk` rise while `ncs` is low. The bit counter clears on the `ncs` fall.
- Commit: on the `ncs` rise, a write commits only if exactly 16 bits were received. Frames with fewer or more than 16 bits are discarded with no side effects.
- Register map (8-bit registers, all reset to 0 except PRESC):
  - `0..B-1`: EN_OUT. Byte k covers channels 8k+7:8k.
  - `B..2B-1`: EN_PWM, same byte layout.
  - `2B`: DUTY.
  - `2B+1`: PRESC.
  - Writes to other addresses are ignored. Reads from other addresses return 8'h00.
- Read path:
  - After the 8th `sclk` rise of a read frame, the addressed register is latched into the TX shift register.
  - `cipo_oe` goes high. On each following synchronised `sclk` fall, `cipo` presents the next bit, starting with data[7].
  - `cipo_oe` and `cipo` are low whenever `ncs` is high, during the header phase, and for the whole of a write frame.
  - Reads never modify state.
- PWM timebase:
  - Prescaler counter counts 0..PRESC. It emits a tick when it equals PRESC, then wraps to 0.
  - An 8-bit period counter increments on each tick and wraps 254→0. The period is 255 ticks.
  - `pwm = (period_cnt < DUTY)`, except DUTY = 8'hFF forces `pwm = 1`. DUTY = 0 gives constant 0.
  - A write to PRESC resets the prescaler counter to 0. The period counter is not reset.
- Output: `outs[i] = EN_OUT[i] ? (EN_PWM[i] ? pwm : 1) : 0`. `outs` is registered.
- Reset: all outputs are 0, including `outs`, `cipo` and `cipo_oe`. All registers, counters and shift registers are cleared, PRESC = DEFAULT_PRESC, and synchronisers are cleared to idle (`ncs` = 1, `sclk` = 0). Asserting reset mid-frame aborts the frame. After release, a frame only starts on a fresh `ncs` fall.

## Timing
- `sclk` high and low phases must each be ≥ `SYNC_STAGES`+1 `clk` periods. `ncs` setup/hold to the first/last `sclk` edge must be ≥ the same.
- Write latency: register value is visible at most `SYNC_STAGES`+2 clk after the `ncs` rise at the pin. `outs` reflects it one clk later.
- Read latency: `cipo` changes `SYNC_STAGES`+2 clk after each `sclk` fall at the pin. The master samples `cipo` on the following `sclk` rise.
- PWM period = 255 × (PRESC+1) clk. High time = DUTY × (PRESC+1) clk.
- A DUTY or EN write takes effect mid-period; no period-boundary alignment.

## Test plan
- Reset, then read every mapped address → EN_OUT/EN_PWM/DUTY read 8'h00, PRESC reads DEFAULT_PRESC, `outs` = 0, `cipo_oe` = 0 outside the data phase.
- Write 8'hA5 to address 0, EN_PWM = 0 → `outs[7:0]` = 8'hA5 within `SYNC_STAGES`+3 clk of the `ncs` rise. Read address 0 → `cipo` shifts 1,0,1,0,0,1,0,1.
- DUTY = 8'h80, PRESC = 3, EN_OUT = EN_PWM = all-ones → each `outs` bit is high 512 clk per 1020-clk period. DUTY = 0 → constant 0. DUTY = 8'hFF → constant 1.
- Frame aborted after 11 bits, and a 17-bit frame → no register changes.
- Write/read to an unmapped address (8'h7F) → no register changes, read returns 8'h00.
- Assert `rst_n` low mid-frame, then complete the bit stream after release → frame ignored, all registers at reset values. Repeat with `CHANNELS` = 8 and 32.
